mlp_layer_engine: RTL and testbench

Parametrised, time-multiplexed fully-connected layer for the MNIST inference datapath. It computes N_OUT neurons over N_IN inputs plus a bias row in fixed-point, then applies a run-time selectable activation (identity, ReLU, or sigmoid via an external LUT ROM) and an argmax. It replaces the per-layer hard-coded sequencing. Several instances, or one reused instance, form the network, with input, weight and LUT memories external.

---
 rtl/mlp_layer_engine_if.sv | 37 +++
 rtl/mlp_layer_engine.sv | 257 +++++++++++++++++++++++++
 tb/tb_mlp_layer_engine.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_layer_engine_if.sv
// Command, status and memory-port bundle of one fully-connected layer engine.
// The host/memory side takes the master modport; the engine takes the slave modport.
interface mlp_layer_engine_if #(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 20,
  parameter int DATA_W = 16,
  parameter int LUT_AW = 10
);
  localparam int XA_W = $clog2(N_IN);
  localparam int WA_W = $clog2(N_IN + 1);
  localparam int AM_W = $clog2(N_OUT);

  logic                      Start;
  logic [1:0]                Mode;
  logic                      Busy;
  logic                      Done;
  logic [XA_W-1:0]           X_Addr;
  logic [DATA_W-1:0]         X_Data;
  logic [WA_W-1:0]           W_Addr;
  logic [N_OUT*DATA_W-1:0]   W_Data;
  logic [LUT_AW-1:0]         Lut_Addr;
  logic [DATA_W-1:0]         Lut_Data;
  logic [N_OUT*DATA_W-1:0]   Y;
  logic                      Y_Valid;
  logic [AM_W-1:0]           Argmax;
  logic                      Overflow;

  modport master (
    output Start, Mode, X_Data, W_Data, Lut_Data,
    input  Busy, Done, X_Addr, W_Addr, Lut_Addr, Y, Y_Valid, Argmax, Overflow
  );

  modport slave (
    input  Start, Mode, X_Data, W_Data, Lut_Data,
    output Busy, Done, X_Addr, W_Addr, Lut_Addr, Y, Y_Valid, Argmax, Overflow
  );
endinterface

// File: rtl/mlp_layer_engine.sv
// Time-multiplexed fully-connected layer: row-serial MAC over N_IN inputs plus a bias row,
// saturation, selectable activation (identity / ReLU / sigmoid ROM) and a sequential argmax.
module mlp_layer_engine #(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 20,
  parameter int DATA_W = 16,
  parameter int FRAC   = 13,
  parameter int ACC_W  = 40,
  parameter int LUT_AW = 10
) (
  input  logic               Clk,
  input  logic               Reset,
  mlp_layer_engine_if.slave  bus
);

  localparam int XA_W   = $clog2(N_IN);
  localparam int WA_W   = $clog2(N_IN + 1);
  localparam int AM_W   = $clog2(N_OUT);
  localparam int CNT_W  = $clog2(((N_IN > N_OUT) ? N_IN : N_OUT) + 2);
  localparam int PROD_W = 2 * DATA_W;

  localparam logic signed [DATA_W-1:0] ONE     = DATA_W'(1 << FRAC);
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [1:0]               MODE_RELU = 2'b01;
  localparam logic [1:0]               MODE_SIG  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_ACT,
    S_ARGMAX,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [1:0]                mode_q, mode_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [XA_W-1:0]           x_addr_q, x_addr_d;
  logic [WA_W-1:0]           w_addr_q, w_addr_d;
  logic [LUT_AW-1:0]         lut_addr_q, lut_addr_d;
  logic signed [ACC_W-1:0]   acc_q [N_OUT];
  logic signed [ACC_W-1:0]   acc_d [N_OUT];
  logic signed [DATA_W-1:0]  z_q [N_OUT];
  logic signed [DATA_W-1:0]  z_d [N_OUT];
  logic signed [DATA_W-1:0]  y_q [N_OUT];
  logic signed [DATA_W-1:0]  y_d [N_OUT];
  logic signed [DATA_W-1:0]  best_q, best_d;
  logic [AM_W-1:0]           argmax_q, argmax_d;
  logic                      y_valid_q, y_valid_d;
  logic                      overflow_q, overflow_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  // Datapath: one row of products, the updated sums and their saturated images.
  logic signed [DATA_W-1:0]  x_in;
  logic signed [PROD_W-1:0]  x_ext;
  logic signed [PROD_W-1:0]  w_ext   [N_OUT];
  logic signed [PROD_W-1:0]  prod    [N_OUT];
  logic signed [PROD_W-1:0]  prod_sh [N_OUT];
  logic signed [ACC_W-1:0]   mac_sum [N_OUT];
  logic signed [DATA_W-1:0]  sat_z   [N_OUT];
  logic [N_OUT-1:0]          sat_ovf;
  logic [N_OUT*DATA_W-1:0]   y_flat;

  function automatic logic [LUT_AW-1:0] lut_index(input logic signed [DATA_W-1:0] z);
    // Offset-binary: flipping the sign bit makes the most negative input address 0.
    return {~z[DATA_W-1], z[DATA_W-2 -: LUT_AW-1]};
  endfunction

  always_comb begin
    // The bias row has no input word; it is multiplied by 1.0 instead.
    x_in  = (cnt_q == CNT_W'(N_IN + 1)) ? ONE : $signed(bus.X_Data);
    x_ext = {{DATA_W{x_in[DATA_W-1]}}, x_in};
    sat_ovf = '0;
    for (int j = 0; j < N_OUT; j++) begin
      w_ext[j]   = {{DATA_W{bus.W_Data[j*DATA_W + DATA_W - 1]}}, bus.W_Data[j*DATA_W +: DATA_W]};
      prod[j]    = x_ext * w_ext[j];
      prod_sh[j] = prod[j] >>> FRAC;
      mac_sum[j] = acc_q[j] + {{(ACC_W-PROD_W){prod_sh[j][PROD_W-1]}}, prod_sh[j]};
      if ((&mac_sum[j][ACC_W-1:DATA_W-1]) | ~(|mac_sum[j][ACC_W-1:DATA_W-1])) begin
        sat_z[j] = mac_sum[j][DATA_W-1:0];
      end else begin
        sat_z[j]   = mac_sum[j][ACC_W-1] ? SAT_MIN : SAT_MAX;
        sat_ovf[j] = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts as its _q so each path assigns every variable; no latches.
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    x_addr_d   = x_addr_q;
    w_addr_d   = w_addr_q;
    lut_addr_d = lut_addr_q;
    best_d     = best_q;
    argmax_d   = argmax_q;
    y_valid_d  = y_valid_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    for (int j = 0; j < N_OUT; j++) begin
      acc_d[j] = acc_q[j];
      z_d[j]   = z_q[j];
      y_d[j]   = y_q[j];
    end

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d    = S_MAC;
          mode_d     = bus.Mode;
          cnt_d      = '0;
          x_addr_d   = '0;
          w_addr_d   = '0;
          y_valid_d  = 1'b0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
          for (int j = 0; j < N_OUT; j++) acc_d[j] = '0;
        end
      end

      S_MAC: begin
        // Cycle k issues row k and consumes the row issued in cycle k-1.
        if (cnt_q != '0) begin
          for (int j = 0; j < N_OUT; j++) acc_d[j] = mac_sum[j];
        end
        if (cnt_q < CNT_W'(N_IN)) begin
          w_addr_d = WA_W'(cnt_q + 1'b1);
          if (cnt_q < CNT_W'(N_IN - 1)) x_addr_d = XA_W'(cnt_q + 1'b1);
        end else begin
          x_addr_d = '0;
          w_addr_d = '0;
        end
        if (cnt_q == CNT_W'(N_IN + 1)) begin
          state_d    = S_ACT;
          cnt_d      = '0;
          overflow_d = overflow_q | (|sat_ovf);
          for (int j = 0; j < N_OUT; j++) z_d[j] = sat_z[j];
          if (mode_q == MODE_SIG) lut_addr_d = lut_index(sat_z[0]);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_ACT: begin
        if (mode_q == MODE_SIG) begin
          // ROM word for neuron j arrives the cycle after its address.
          for (int j = 0; j < N_OUT; j++) begin
            if (cnt_q == CNT_W'(j + 1)) y_d[j] = bus.Lut_Data;
          end
          lut_addr_d = '0;
          for (int j = 1; j < N_OUT; j++) begin
            if (cnt_q == CNT_W'(j - 1)) lut_addr_d = lut_index(z_q[j]);
          end
          if (cnt_q == CNT_W'(N_OUT)) begin
            state_d = S_ARGMAX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          for (int j = 0; j < N_OUT; j++) begin
            y_d[j] = (mode_q == MODE_RELU && z_q[j][DATA_W-1]) ? '0 : z_q[j];
          end
          state_d = S_ARGMAX;
          cnt_d   = '0;
        end
      end

      S_ARGMAX: begin
        // Strict greater-than keeps the lowest index on ties.
        for (int j = 0; j < N_OUT; j++) begin
          if (cnt_q == CNT_W'(j) && (j == 0 || y_q[j] > best_q)) begin
            best_d   = y_q[j];
            argmax_d = AM_W'(j);
          end
        end
        if (cnt_q == CNT_W'(N_OUT - 1)) begin
          state_d   = S_DONE;
          cnt_d     = '0;
          done_d    = 1'b1;
          y_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= only, so every flop samples the pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      cnt_q      <= '0;
      x_addr_q   <= '0;
      w_addr_q   <= '0;
      lut_addr_q <= '0;
      best_q     <= '0;
      argmax_q   <= '0;
      y_valid_q  <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      // NOTE: these arrays are N_OUT-wide register banks, not RAM, so they take the reset.
      for (int j = 0; j < N_OUT; j++) begin
        acc_q[j] <= '0;
        z_q[j]   <= '0;
        y_q[j]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      x_addr_q   <= x_addr_d;
      w_addr_q   <= w_addr_d;
      lut_addr_q <= lut_addr_d;
      best_q     <= best_d;
      argmax_q   <= argmax_d;
      y_valid_q  <= y_valid_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      for (int j = 0; j < N_OUT; j++) begin
        acc_q[j] <= acc_d[j];
        z_q[j]   <= z_d[j];
        y_q[j]   <= y_d[j];
      end
    end
  end

  always_comb begin
    y_flat = '0;
    for (int j = 0; j < N_OUT; j++) y_flat[j*DATA_W +: DATA_W] = y_q[j];
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.X_Addr   = x_addr_q;
  assign bus.W_Addr   = w_addr_q;
  assign bus.Lut_Addr = lut_addr_q;
  assign bus.Y        = y_flat;
  assign bus.Y_Valid  = y_valid_q;
  assign bus.Argmax   = argmax_q;
  assign bus.Overflow = overflow_q;

endmodule

// File: tb/tb_mlp_layer_engine.sv
// Scoreboard bench for mlp_layer_engine at N_IN=4, N_OUT=3: directed passes push expected
// results; a Done-triggered monitor pops and compares outputs and latency.
module tb_mlp_layer_engine;

  localparam int N_IN   = 4;
  localparam int N_OUT  = 3;
  localparam int DATA_W = 16;
  localparam int FRAC   = 13;
  localparam int ACC_W  = 40;
  localparam int LUT_AW = 10;

  localparam logic [1:0] M_ID  = 2'b00;
  localparam logic [1:0] M_RLU = 2'b01;
  localparam logic [1:0] M_SIG = 2'b10;

  typedef struct {
    logic [N_OUT*DATA_W-1:0] y;
    int                      argmax;
    int                      ovf;
    int                      lat;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  mlp_layer_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .LUT_AW(LUT_AW)) bus ();

  mlp_layer_engine #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .FRAC(FRAC), .ACC_W(ACC_W), .LUT_AW(LUT_AW)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // External memories: 1-cycle synchronous reads; the sigmoid ROM returns its own address.
  logic signed [DATA_W-1:0] x_mem [N_IN];
  logic [N_OUT*DATA_W-1:0]  w_mem [N_IN+1];

  always @(posedge Clk) begin
    bus.X_Data   <= x_mem[bus.X_Addr];
    bus.W_Data   <= w_mem[bus.W_Addr];
    bus.Lut_Data <= DATA_W'(bus.Lut_Addr);
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int   checks   = 0;
  int   failures = 0;
  int   accept_cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_OUT*DATA_W-1:0] pack3(input int a, input int b, input int c);
    logic [DATA_W-1:0] va, vb, vc;
    va = DATA_W'(a);
    vb = DATA_W'(b);
    vc = DATA_W'(c);
    return {vc, vb, va};
  endfunction

  function automatic longint y_at(input logic [N_OUT*DATA_W-1:0] y, input int j);
    logic signed [DATA_W-1:0] v;
    v = y[j*DATA_W +: DATA_W];
    return longint'(v);
  endfunction

  function automatic exp_t mk(input int a, input int b, input int c, input int am, input int ov,
                              input int lat);
    exp_t e;
    e.y = pack3(a, b, c);
    e.argmax = am;
    e.ovf = ov;
    e.lat = lat;
    return e;
  endfunction

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (bus.Done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        for (int j = 0; j < N_OUT; j++)
          check($sformatf("y[%0d]", j), y_at(bus.Y, j), y_at(mon_e.y, j));
        check("argmax", longint'(bus.Argmax), mon_e.argmax);
        check("overflow", longint'(bus.Overflow), mon_e.ovf);
        check("y_valid_at_done", longint'(bus.Y_Valid), 1);
        check("latency", cyc - accept_cyc, mon_e.lat);
      end
    end
  end

  task automatic set_data(input int xv, input logic [N_OUT*DATA_W-1:0] wrow,
                          input logic [N_OUT*DATA_W-1:0] brow);
    for (int i = 0; i < N_IN; i++) begin
      x_mem[i] = DATA_W'(xv);
      w_mem[i] = wrow;
    end
    w_mem[N_IN] = brow;
  endtask

  task automatic start(input logic [1:0] mode, input exp_t e, input bit push);
    @(negedge Clk);
    bus.Mode   = mode;
    bus.Start  = 1'b1;
    accept_cyc = cyc;
    if (push) exp_q.push_back(e);
    @(negedge Clk);
    bus.Start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.Done && n < 300) begin
      @(negedge Clk);
      n++;
    end
    if (!bus.Done) check("done_timeout", 0, 1);
  endtask

  task automatic run_pass(input logic [1:0] mode, input exp_t e);
    start(mode, e, 1'b1);
    check("busy_in_pass", longint'(bus.Busy), 1);
    wait_done();
    @(negedge Clk);
    check("busy_after_done", longint'(bus.Busy), 0);
    check("y_valid_held", longint'(bus.Y_Valid), 1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_y"}, longint'(bus.Y), 0);
    check({tag, "_y_valid"}, longint'(bus.Y_Valid), 0);
    check({tag, "_argmax"}, longint'(bus.Argmax), 0);
    check({tag, "_overflow"}, longint'(bus.Overflow), 0);
    check({tag, "_busy"}, longint'(bus.Busy), 0);
    check({tag, "_done"}, longint'(bus.Done), 0);
    check({tag, "_x_addr"}, longint'(bus.X_Addr), 0);
    check({tag, "_w_addr"}, longint'(bus.W_Addr), 0);
    check({tag, "_lut_addr"}, longint'(bus.Lut_Addr), 0);
  endtask

  logic [N_OUT*DATA_W-1:0] w_std, b_zero;

  initial begin
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Mode  = 2'b00;
    w_std  = pack3(4096, -4096, 8192);
    b_zero = pack3(0, 0, 0);
    set_data(8192, w_std, b_zero);
    repeat (3) @(negedge Clk);
    check_cleared("reset");
    Reset = 1'b0;

    // 1.0 * {0.5, -0.5, 1.0} over four rows; neuron 2 saturates.
    run_pass(M_ID,  mk(16384, -16384, 32767, 2, 1, 11));
    run_pass(M_RLU, mk(16384, 0, 32767, 2, 1, 11));
    run_pass(M_SIG, mk(768, 256, 1023, 2, 1, 14));

    // Bias-only result with a tie between neurons 1 and 2.
    set_data(8192, b_zero, pack3(-8192, 8192, 8192));
    run_pass(M_ID, mk(-8192, 8192, 8192, 1, 0, 11));

    // Start pulsed mid-MAC must be ignored.
    set_data(8192, w_std, b_zero);
    start(M_ID, mk(16384, -16384, 32767, 2, 1, 11), 1'b1);
    repeat (2) @(negedge Clk);
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    wait_done();
    @(negedge Clk);

    // Reset during sigmoid ACT aborts the pass with no Done.
    start(M_SIG, mk(0, 0, 0, 0, 0, 0), 1'b0);
    repeat (7) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check_cleared("abort");
    Reset = 1'b0;
    repeat (20) @(negedge Clk);

    // Fresh pass after the abort.
    run_pass(M_RLU, mk(16384, 0, 32767, 2, 1, 11));

    // Back-to-back: Start is held through DONE (ignored) and accepted in the following cycle.
    start(M_ID, mk(16384, -16384, 32767, 2, 1, 11), 1'b1);
    wait_done();
    set_data(1, pack3(-1, 1, 0), b_zero);
    bus.Mode  = M_ID;
    bus.Start = 1'b1;
    @(negedge Clk);
    accept_cyc = cyc;
    exp_q.push_back(mk(-4, 0, 0, 1, 0, 11));
    @(negedge Clk);
    bus.Start = 1'b0;
    check("b2b_y_valid_cleared", longint'(bus.Y_Valid), 0);
    check("b2b_overflow_cleared", longint'(bus.Overflow), 0);
    check("b2b_y1_held", y_at(bus.Y, 1), -16384);
    check("b2b_busy", longint'(bus.Busy), 1);
    wait_done();
    repeat (3) @(negedge Clk);

    check("pending_expectations", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
